// File: rtl/activation_stage.sv
// -----------------------------------------------------------------------------
// activation_stage
//
// Purpose:
//   Sits after the fully-connected layer block. It captures that layer's flat
//   Q8.8 output vector on start. It then applies ReLU, with an optional upper
//   clip, one element per clock. The result goes to a registered flat vector
//   with a level-held done flag.
//
// Parameters:
//   M    - number of vector elements
//   W    - element width (signed Q8.8)
//   CLIP - signed Q8.8 upper clamp; 0 disables the clamp
//
// Ports:
//   clk   in   1    system clock, rising edge
//   rst   in   1    synchronous reset, active-high
//   start in   1    request to process x (sampled only when not busy)
//   x     in   M*W  input vector, element i at [i*W +: W]
//   y     out  M*W  registered result vector, same packing as x
//   busy  out  1    high while elements are being processed
//   done  out  1    high once y is complete; held until next accepted start/rst
//
// Build option:
//   ACTIVATION_LEAKY_EN - when defined, negative inputs map to v >>> 3
//                         (leaky ReLU, slope 1/8) instead of zero.
// -----------------------------------------------------------------------------
module activation_stage #(
    parameter int M    = 2,
    parameter int W    = 16,
    parameter int CLIP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [M*W-1:0]   x,
    output logic [M*W-1:0]   y,
    output logic             busy,
    output logic             done
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic signed [W-1:0] CLIP_V = W'(CLIP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [M*W-1:0]  xbuf_q;
    logic [IW-1:0]   idx_q;
    logic [M*W-1:0]  y_q;
    logic            busy_q;
    logic            done_q;

    // Transfer function. Everything stays at W bits. The clip only ever
    // lowers a positive value, and the shift cannot grow magnitude, so
    // no overflow is possible.
    function automatic logic [W-1:0] act_f(input logic signed [W-1:0] v);
        logic [W-1:0] r;
        if (v < 0) begin
`ifdef ACTIVATION_LEAKY_EN
            r = v >>> 3;
`else
            r = '0;
`endif
        end else if ((CLIP != 0) && (v > CLIP_V)) begin
            r = CLIP_V;
        end else begin
            r = v;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            xbuf_q  <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                // IDLE and DONE differ only in the done flag. A start from
                // DONE re-arms immediately, and done drops on the accept edge.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        xbuf_q  <= x;
                        idx_q   <= '0;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored here.
                    y_q[idx_q*W +: W] <= act_f(xbuf_q[idx_q*W +: W]);
                    if (idx_q == IW'(M - 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
